// File: rtl/udc_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : udc_bus_arbiter                                              |
// | Description : Two-port arbiter and bus sequencer for the up/down counter   |
// |               host bus. Accepts one write/read/start command at a time     |
// |               via valid/ready. Runs it on the counter pins using fixed     |
// |               SETUP / STROBE / HOLD phases. Returns a completion pulse     |
// |               (plus read data) to the requester that issued it.            |
// | Options     : UDC_ARB_RR_EN defined   -> round-robin arbitration          |
// |               UDC_ARB_RR_EN undefined -> fixed priority, req0 wins        |
// | Parameters  : STROBE_CYC  cycles nwr/nrd are held low (1..15)              |
// | Ports       : clk, reset (sync, active-high)                               |
// |               reqN_valid/ready/op/addr/wdata  command channel, N = 0,1     |
// |               rspN_valid/rdata                completion channel           |
// |               ncs, nwr, nrd, A0, A1, start_in counter control pins         |
// |               din (inout, 8)                  counter data bus             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module udc_bus_arbiter #(
  parameter int STROBE_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_op,
  input  logic [1:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_rdata,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_op,
  input  logic [1:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_rdata,
  output logic       ncs,
  output logic       nwr,
  output logic       nrd,
  output logic       A0,
  output logic       A1,
  output logic       start_in,
  inout  wire  [7:0] din
);

  localparam logic [1:0] c_OP_WR     = 2'b00;
  localparam logic [1:0] c_OP_RD     = 2'b01;
  localparam logic [1:0] c_OP_ST     = 2'b10;
  localparam logic [3:0] c_STROBE_LD = 4'(STROBE_CYC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_START  = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_op;
  logic [1:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_id;
  logic [3:0] r_cnt;
  logic [7:0] r_rdata0;
  logic [7:0] r_rdata1;

  logic       w_idle;
  logic       w_prio0;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_accept;
  logic [1:0] w_acc_op;
  logic [1:0] w_acc_addr;
  logic [7:0] w_acc_wdata;
  logic       w_bus_op;
  logic       w_bus_phase;
  logic       w_last_strobe;
  logic       w_rsp;

  // ---------------------------------------------------------------------------
  // Arbitration (IDLE only). w_prio0 says requester 0 wins a tie.
  // ---------------------------------------------------------------------------
`ifdef UDC_ARB_RR_EN
  // r_ptr = 1 means requester 1 has priority on the next tie.
  logic r_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (w_accept) begin
      r_ptr <= ~w_gnt1;
    end
  end

  assign w_prio0 = ~r_ptr;
`else
  assign w_prio0 = 1'b1;
`endif

  assign w_idle   = (r_state == S_IDLE);
  assign w_gnt0   = w_idle && !reset && req0_valid && (w_prio0 || !req1_valid);
  assign w_gnt1   = w_idle && !reset && req1_valid && !w_gnt0;
  assign w_accept = w_gnt0 || w_gnt1;

  assign w_acc_op    = w_gnt1 ? req1_op    : req0_op;
  assign w_acc_addr  = w_gnt1 ? req1_addr  : req0_addr;
  assign w_acc_wdata = w_gnt1 ? req1_wdata : req0_wdata;

  // Writes and reads use the bus; start and reserved never touch ncs/din.
  assign w_bus_op      = (r_op == c_OP_WR) || (r_op == c_OP_RD);
  assign w_bus_phase   = w_bus_op &&
                         ((r_state == S_SETUP) || (r_state == S_STROBE) || (r_state == S_HOLD));
  assign w_last_strobe = (r_state == S_STROBE) && (r_cnt <= 4'd1);
  assign w_rsp         = (r_state == S_HOLD) || (r_state == S_START);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and pin outputs (Moore decode of the registered state)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = w_gnt0;
    req1_ready  = w_gnt1;
    ncs         = ~w_bus_phase;
    nwr         = ~((r_state == S_STROBE) && (r_op == c_OP_WR));
    nrd         = ~((r_state == S_STROBE) && (r_op == c_OP_RD));
    A0          = w_bus_phase & r_addr[0];
    A1          = w_bus_phase & r_addr[1];
    start_in    = (r_state == S_START);
    rsp0_valid  = w_rsp && !r_id;
    rsp1_valid  = w_rsp &&  r_id;
    // Non-read completions report zero; otherwise the last read value is held.
    rsp0_rdata  = (rsp0_valid && (r_op != c_OP_RD)) ? 8'h00 : r_rdata0;
    rsp1_rdata  = (rsp1_valid && (r_op != c_OP_RD)) ? 8'h00 : r_rdata1;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (w_acc_op)
            c_OP_WR, c_OP_RD: w_state_nxt = S_SETUP;
            c_OP_ST:          w_state_nxt = S_START;
            default:          w_state_nxt = S_HOLD;   // reserved: respond only
          endcase
        end
      end
      S_SETUP:  w_state_nxt = S_STROBE;
      S_STROBE: if (w_last_strobe) w_state_nxt = S_HOLD;
      S_HOLD:   w_state_nxt = S_IDLE;
      S_START:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch, strobe counter and read capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= c_OP_WR;
      r_addr   <= 2'b00;
      r_wdata  <= 8'h00;
      r_id     <= 1'b0;
      r_cnt    <= 4'd0;
      r_rdata0 <= 8'h00;
      r_rdata1 <= 8'h00;
    end else begin
      if (w_accept) begin
        r_op    <= w_acc_op;
        r_addr  <= w_acc_addr;
        r_wdata <= w_acc_wdata;
        r_id    <= w_gnt1;
      end
      // Loaded during SETUP so the first STROBE cycle sees the full count.
      if (r_state == S_SETUP) begin
        r_cnt <= c_STROBE_LD;
      end else if (r_state == S_STROBE) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_last_strobe && (r_op == c_OP_RD)) begin
        if (r_id) begin
          r_rdata1 <= din;
        end else begin
          r_rdata0 <= din;
        end
      end
    end
  end

  assign din = (w_bus_phase && (r_op == c_OP_WR)) ? r_wdata : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_udc_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_udc_bus_arbiter                                           |
// | Description : Scoreboard bench for udc_bus_arbiter. Main DUT uses          |
// |               STROBE_CYC=2. A second instance with STROBE_CYC=1 covers     |
// |               back-to-back commands. Honors UDC_ARB_RR_EN.                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_udc_bus_arbiter;

  localparam int         c_S    = 2;
  localparam logic [1:0] c_WR   = 2'b00;
  localparam logic [1:0] c_RD   = 2'b01;
  localparam logic [1:0] c_ST   = 2'b10;
  localparam logic [1:0] c_RSV  = 2'b11;
`ifdef UDC_ARB_RR_EN
  localparam bit         c_RR   = 1'b1;
`else
  localparam bit         c_RR   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0] req0_op = 2'b00, req1_op = 2'b00, req0_addr = 2'b00, req1_addr = 2'b00;
  logic [7:0] req0_wdata = 8'h00, req1_wdata = 8'h00;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       ncs, nwr, nrd, A0, A1, start_in;
  wire  [7:0] din;
  logic [7:0] cnt_rd_val = 8'h00;   // value the counter model returns on reads

  assign din = (!nrd) ? cnt_rd_val : 8'hzz;

  always #5 clk = ~clk;

  udc_bus_arbiter #(.STROBE_CYC(c_S)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ncs(ncs), .nwr(nwr), .nrd(nrd), .A0(A0), .A1(A1), .start_in(start_in),
    .din(din)
  );

  // Second instance, STROBE_CYC=1, only requester 0 used.
  logic       b_valid = 1'b0, b_req1_valid = 1'b0;
  logic [1:0] b_op = 2'b00, b_addr = 2'b00, b_req1_op = 2'b00, b_req1_addr = 2'b00;
  logic [7:0] b_wdata = 8'h00, b_req1_wdata = 8'h00;
  logic       b_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
  logic [7:0] b_rsp0_rdata, b_rsp1_rdata;
  logic       b_ncs, b_nwr, b_nrd, b_A0, b_A1, b_start;
  wire  [7:0] b_din;

  assign b_din = (!b_nrd) ? 8'hC3 : 8'hzz;

  udc_bus_arbiter #(.STROBE_CYC(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(b_valid), .req0_ready(b_ready), .req0_op(b_op),
    .req0_addr(b_addr), .req0_wdata(b_wdata),
    .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_op(b_req1_op),
    .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata),
    .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
    .ncs(b_ncs), .nwr(b_nwr), .nrd(b_nrd), .A0(b_A0), .A1(b_A1), .start_in(b_start),
    .din(b_din)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: timing of the accepted command relative to acceptance
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         id;
    logic [7:0] rdata;
    int         due;
  } rsp_t;

  rsp_t       sb[$];
  bit         glog[$];
  int         cyc = 0;
  bit         act = 1'b0;
  int         acc_t = 0;
  logic [1:0] acc_op = 2'b00, acc_addr = 2'b00;
  logic [7:0] acc_wd = 8'h00;
  bit         ptr = 1'b0;
  bit         pend_v = 1'b0, pend_id = 1'b0;
  logic [1:0] pend_op = 2'b00, pend_addr = 2'b00;
  logic [7:0] pend_wd = 8'h00;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      act    = 1'b0;
      ptr    = 1'b0;
      pend_v = 1'b0;
      sb.delete();
    end else if (pend_v) begin
      act      = 1'b1;
      acc_t    = cyc;
      acc_op   = pend_op;
      acc_addr = pend_addr;
      acc_wd   = pend_wd;
      if (c_RR) ptr = !pend_id;
      glog.push_back(pend_id);
      sb.push_back('{pend_id, (pend_op == c_RD) ? cnt_rd_val : 8'h00,
                     cyc + ((pend_op[1] == 1'b0) ? c_S + 1 : 0)});
      pend_v = 1'b0;
    end
  end

  always @(negedge clk) begin : mon
    int         p;
    bit         bus, busy, inbus;
    logic [1:0] e_rdy;
    logic [7:0] e_vec;
    rsp_t       r;
    if (cyc > 0) begin
      p     = cyc - acc_t;
      bus   = act && (acc_op[1] == 1'b0);
      busy  = act && (bus ? (p <= c_S + 1) : (p == 0));
      inbus = bus && (p <= c_S + 1);
      if (reset || busy)                 e_rdy = 2'b00;
      else if (req0_valid && req1_valid) e_rdy = (c_RR && ptr) ? 2'b10 : 2'b01;
      else                               e_rdy = {req1_valid, req0_valid};
      e_vec = {e_rdy,
               !inbus,
               !(act && acc_op == c_WR && p >= 1 && p <= c_S),
               !(act && acc_op == c_RD && p >= 1 && p <= c_S),
               (act && acc_op == c_ST && p == 0),
               inbus ? acc_addr : 2'b00};
      check_eq("pins", {req1_ready, req0_ready, ncs, nwr, nrd, start_in, A1, A0}, e_vec);
      if (inbus && acc_op == c_WR) check_eq("din_wr", din, acc_wd);

      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          check_eq("rsp_spurious", {rsp1_valid, rsp0_valid}, 2'b00);
        end else begin
          r = sb.pop_front();
          check_eq("rsp_port", {rsp1_valid, rsp0_valid}, r.id ? 2'b10 : 2'b01);
          check_eq("rsp_rdata", r.id ? rsp1_rdata : rsp0_rdata, r.rdata);
          check_eq("rsp_cycle", cyc, r.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        r = sb.pop_front();
        check_eq("rsp_missing", 0, 1);
      end

      pend_v    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
      pend_id   = req1_valid && req1_ready;
      pend_op   = pend_id ? req1_op    : req0_op;
      pend_addr = pend_id ? req1_addr  : req0_addr;
      pend_wd   = pend_id ? req1_wdata : req0_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic send(input bit id, input logic [1:0] op, input logic [1:0] addr,
                      input logic [7:0] wd);
    @(posedge clk); #2;
    if (id) begin
      req1_op = op; req1_addr = addr; req1_wdata = wd; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_addr = addr; req0_wdata = wd; req0_valid = 1'b1;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        @(posedge clk); #2;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        return;
      end
    end
    check_eq("send_timeout", 0, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int t_acc[2];
  int n_acc, n_rsp;
  bit acc;

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_rdata", {rsp1_rdata, rsp0_rdata}, 16'h0000);
    check_eq("rst_pins", {ncs, nwr, nrd, start_in, A1, A0, rsp1_valid, rsp0_valid}, 8'b1110_0000);
    reset = 1'b0;

    // write on req0, addr 2, 5A
    send(0, c_WR, 2'd2, 8'h5A);
    repeat (6) @(posedge clk);
    #2 check_eq("din_released", {31'd0, din === 8'h5A}, 0);

    // read on req1, addr 1, counter returns 3C
    cnt_rd_val = 8'h3C;
    send(1, c_RD, 2'd1, 8'h00);
    repeat (6) @(posedge clk);
    #2 check_eq("rd_hold_idle", rsp1_rdata, 8'h3C);

    // a write on req1 must not disturb the held read value
    send(1, c_WR, 2'd3, 8'h11);
    repeat (6) @(posedge clk);
    #2 check_eq("rd_hold_after_wr", rsp1_rdata, 8'h3C);

    // start and reserved
    send(0, c_ST, 2'd0, 8'h00);
    repeat (3) @(posedge clk);
    send(1, c_RSV, 2'd1, 8'hFF);
    repeat (3) @(posedge clk);

    // both requesters hold writes continuously
    glog.delete();
    @(posedge clk); #2;
    req0_op = c_WR; req0_addr = 2'd0; req0_wdata = 8'hA0; req0_valid = 1'b1;
    req1_op = c_WR; req1_addr = 2'd3; req1_wdata = 8'hB1; req1_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #2;
      if (glog.size() >= 4) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("arb_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      check_eq("arb_grant", {31'd0, glog[i]}, c_RR ? (i % 2) : 0);
    repeat (6) @(posedge clk);

    // valid dropped before ready: no effect
    glog.delete();
    send(0, c_WR, 2'd1, 8'h33);
    req1_op = c_RD; req1_valid = 1'b1;
    @(posedge clk); #2;
    req1_valid = 1'b0;
    repeat (6) @(posedge clk);
    check_eq("drop_valid", glog.size(), 1);

    // reset during STROBE of a write
    send(0, c_WR, 2'd1, 8'hA5);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    check_eq("abort_pins", {nwr, ncs, rsp0_valid, rsp1_valid}, 4'b1100);
    check_eq("abort_din", {31'd0, din === 8'hA5}, 0);
    reset = 1'b0;
    glog.delete();
    cnt_rd_val = 8'h77;
    send(1, c_RD, 2'd0, 8'h00);
    repeat (6) @(posedge clk);
    check_eq("post_reset_accept", glog.size(), 1);

    // STROBE_CYC=1 instance: read then write back-to-back on req0
    n_acc = 0;
    n_rsp = 0;
    @(posedge clk); #2;
    b_op = c_RD; b_addr = 2'd1; b_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("b_no_overlap", {31'd0, b_nrd | b_nwr}, 1);
      if (b_rsp0_valid) begin
        n_rsp++;
        check_eq("b_rsp_rdata", b_rsp0_rdata, (n_rsp == 1) ? 8'hC3 : 8'h00);
      end
      acc = b_valid && b_ready;
      @(posedge clk);
      if (acc && n_acc < 2) begin
        t_acc[n_acc] = i;
        n_acc++;
      end
      #2;
      if (acc && n_acc == 1) begin
        b_op = c_WR; b_addr = 2'd2; b_wdata = 8'h5A;
      end else if (acc && n_acc == 2) begin
        b_valid = 1'b0;
      end
    end
    check_eq("b_accepts", n_acc, 2);
    check_eq("b_gap", t_acc[1] - t_acc[0], 4);
    check_eq("b_rsps", n_rsp, 2);

    repeat (4) @(posedge clk);
    check_eq("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
